// File: rtl/commit_sched.sv
// ROB retirement scheduler: picks the in-order retire prefix, drives the registered
// commit bus, handshakes stores with the store path and pulses flush after a mispredict.
module commit_sched #(
    parameter int unsigned MAX_COMMITS = 2,
    parameter int unsigned ROB_W       = 5,
    parameter int unsigned AREG_W      = 5,
    parameter int unsigned PREG_W      = 6,
    parameter int unsigned VAL_W       = 32
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [ROB_W-1:0]                  rob_head_ptr,
    input  logic [ROB_W:0]                    rob_count,
    input  logic [MAX_COMMITS-1:0]            head_ready,
    input  logic [2*MAX_COMMITS-1:0]          head_type,
    input  logic [MAX_COMMITS-1:0]            head_mispred,
    input  logic [AREG_W*MAX_COMMITS-1:0]     head_arch_reg,
    input  logic [PREG_W*MAX_COMMITS-1:0]     head_phy_reg,
    input  logic [VAL_W*MAX_COMMITS-1:0]      head_value,
    output logic [$clog2(MAX_COMMITS+1)-1:0]  rob_retire_cnt,
    output logic                              store_req,
    output logic [ROB_W-1:0]                  store_tag,
    input  logic                              store_ack,
    output logic [MAX_COMMITS-1:0]            commit_valid,
    output logic [ROB_W*MAX_COMMITS-1:0]      commit_tag,
    output logic [AREG_W*MAX_COMMITS-1:0]     commit_arch_reg_addr,
    output logic [PREG_W*MAX_COMMITS-1:0]     commit_phy_reg_addr,
    output logic [VAL_W*MAX_COMMITS-1:0]      commit_value,
    output logic [2*MAX_COMMITS-1:0]          commit_type,
    output logic                              flush
);

    localparam int unsigned CNT_W = $clog2(MAX_COMMITS + 1);
    localparam logic [1:0]  T_STORE  = 2'd1;
    localparam logic [1:0]  T_BRANCH = 2'd2;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STORE_WAIT = 2'd1,
        FLUSH      = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       k;
    logic                   store_hit;
    logic                   mispred_hit;
    logic                   stop;
    logic [MAX_COMMITS-1:0] valid_d;
    logic                   store_req_d;
    logic                   store_load;
    logic                   flush_d;

    // Eligible in-order prefix with store / mispredict truncation
    always_comb begin
        k           = '0;
        store_hit   = 1'b0;
        mispred_hit = 1'b0;
        stop        = 1'b0;
        for (int i = 0; i < int'(MAX_COMMITS); i++) begin
            if (!stop) begin
                if (((ROB_W+1)'(i) < rob_count) && head_ready[i]) begin
                    if (head_type[2*i +: 2] == T_STORE) begin
                        store_hit = (i == 0);
                        stop      = 1'b1;
                    end else begin
                        k = CNT_W'(i + 1);
                        if ((head_type[2*i +: 2] == T_BRANCH) && head_mispred[i]) begin
                            mispred_hit = 1'b1;
                            stop        = 1'b1;
                        end
                    end
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (store_hit)        state_nxt = STORE_WAIT;
                else if (mispred_hit) state_nxt = FLUSH;
            end
            STORE_WAIT: if (store_ack) state_nxt = RUN;
            FLUSH:      state_nxt = RUN;
            default:    state_nxt = RUN;
        endcase
    end

    // Retire count and next values of the registered outputs
    always_comb begin
        rob_retire_cnt = '0;
        store_req_d    = 1'b0;
        store_load     = 1'b0;
        flush_d        = 1'b0;
        valid_d        = '0;
        if (reset_n) begin
            case (state)
                RUN: begin
                    rob_retire_cnt = k;
                    store_req_d    = store_hit;
                    store_load     = store_hit;
                    flush_d        = mispred_hit;
                end
                STORE_WAIT: begin
                    rob_retire_cnt = store_ack ? CNT_W'(1) : '0;
                    store_req_d    = !store_ack;
                end
                default: ;
            endcase
        end
        for (int i = 0; i < int'(MAX_COMMITS); i++) begin
            valid_d[i] = (CNT_W'(i) < rob_retire_cnt);
        end
    end

    // State and output registers; data of non-committing slots is held
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state                <= RUN;
            commit_valid         <= '0;
            commit_tag           <= '0;
            commit_arch_reg_addr <= '0;
            commit_phy_reg_addr  <= '0;
            commit_value         <= '0;
            commit_type          <= '0;
            store_req            <= 1'b0;
            store_tag            <= '0;
            flush                <= 1'b0;
        end else begin
            state        <= state_nxt;
            commit_valid <= valid_d;
            store_req    <= store_req_d;
            flush        <= flush_d;
            if (store_load) store_tag <= rob_head_ptr;
            for (int i = 0; i < int'(MAX_COMMITS); i++) begin
                if (valid_d[i]) begin
                    commit_tag[ROB_W*i +: ROB_W]             <= rob_head_ptr + ROB_W'(i);
                    commit_arch_reg_addr[AREG_W*i +: AREG_W] <= head_arch_reg[AREG_W*i +: AREG_W];
                    commit_phy_reg_addr[PREG_W*i +: PREG_W]  <= head_phy_reg[PREG_W*i +: PREG_W];
                    commit_value[VAL_W*i +: VAL_W]           <= head_value[VAL_W*i +: VAL_W];
                    commit_type[2*i +: 2]                    <= head_type[2*i +: 2];
                end
            end
        end
    end

endmodule
